tile_feeder: RTL and testbench
==============================

TILE_FEEDER -- requirements
Module: tile_feeder

Interface
REQ-001 SHALL have parameters: ROWS, default 2, PE rows in the array; COLS, default 2, PE columns; DATA_WIDTH, default 16, signed fixed-point word width.
REQ-002 SHALL have ports, one clock and one reset, with reset synchronous and active-low:
  clk  in  1  rising-edge clock for all state
  rst  in  1  synchronous reset, active-low (0 = reset)
  w_valid  in  1  host weight beat valid
  w_ready  out  1  feeder accepts weight beat
  w_data  in  DATA_WIDTH  signed weight, row-major order (index r*COLS+c)
  x_valid  in  1  host input vector valid
  x_ready  out  1  feeder accepts input vector
  x_data  in  ROWS*DATA_WIDTH  one input vector; element r in bits [r*DATA_WIDTH +: DATA_WIDTH]
  x_last  in  1  qualifies final vector of batch (sampled only with x_valid&&x_ready)
  pe_weight_o  out  COLS*DATA_WIDTH  north-edge weight per column
  pe_accept_w_o  out  COLS  north-edge accept-weight per column
  pe_input_o  out  ROWS*DATA_WIDTH  west-edge input per row
  pe_valid_o  out  ROWS  west-edge valid per row
  pe_switch_o  out  ROWS  west-edge switch per row
  busy  out  1  high in every state except LOAD_W
  done  out  1  one-cycle batch-complete pulse

Function
REQ-003 SHALL implement FSM states LOAD_W, DRIVE_W, SWITCH, STREAM, DRAIN; reset state LOAD_W.
REQ-004 LOAD_W: w_ready=1, x_ready=0; each w_valid&&w_ready beat stored to tile[idx], idx increments; after beat ROWS*COLS-1, idx wraps to 0 and FSM goes to DRIVE_W.
REQ-005 DRIVE_W: lasts exactly ROWS cycles, k=0..ROWS-1; define T0 as the first cycle pe_accept_w_o is high; at T0+k every column c presents tile[ROWS-1-k][c] with pe_accept_w_o[c]=1 (bottom row first, all columns in parallel).
REQ-006 Outside DRIVE_W output timing, pe_accept_w_o SHALL be 0 and pe_weight_o SHALL be 0.
REQ-007 SWITCH: one cycle; injects a switch pulse into the row skew line so pe_switch_o[r] is high for exactly one cycle at T0+ROWS+r.
REQ-008 STREAM: x_ready=1; each accepted vector j enters the skew line; element r appears on pe_input_o[r] with pe_valid_o[r]=1 at T0+ROWS+1+j+r under continuous x_valid.
REQ-009 Cycle in STREAM with x_valid=0: a bubble (valid 0, input 0) enters the skew line; relative row skew preserved.
REQ-010 Skew line: row r output delayed r cycles relative to row 0; all outputs registered; row 0 one cycle after handshake/state entry.
REQ-011 On accepting vector with x_last=1: FSM goes to DRAIN, x_ready=0 thereafter.
REQ-012 DRAIN: remains until last vector's element reaches row ROWS-1; done=1 exactly in that cycle; next cycle LOAD_W (ROWS=1: done in the cycle following acceptance).
REQ-013 pe_valid_o[r]=0 SHALL force pe_input_o[r]=0.
REQ-014 No arithmetic on data; counters sized $clog2 of their range, minimum 1 bit.
REQ-015 w_valid outside LOAD_W and x_valid outside STREAM SHALL be ignored with no state change.

Reset
REQ-016 rst=0 at a clock edge: FSM to LOAD_W, idx/k/drain counters 0, skew line cleared, all pe_* outputs 0, busy=0, done=0, w_ready=1 after reset release.
REQ-017 Reset mid-operation abandons the batch; no partial weight, switch, or input SHALL be emitted after reset; tile contents are don't-care.

Structure
REQ-018 Shared package tpu_pkg SHALL hold DATA_WIDTH default and feeder_state_t enum.
REQ-019 Sub-module skew_delay (parameter DEPTH, DATA_WIDTH; carries data, valid, switch) SHALL be instantiated once per row with DEPTH=r.

Verification (ROWS=COLS=2)
REQ-020 rst low 2 cycles -> all pe_* 0, done 0, busy 0, w_ready 1, x_ready 0.
REQ-021 weights 1,2,3,4 -> T0: pe_weight_o={4,3} (col1,col0), accept=11; T0+1: {2,1}, 11; T0+2: accept 00; pe_switch_o[0] at T0+2, [1] at T0+3.
REQ-022 vectors [5,6],[7,8],[9,10], x_last on third -> row0 5,7,9 at T0+3..5; row1 6,8,10 at T0+4..6; done at T0+6 only.
REQ-023 one-cycle x_valid gap after [5,6] -> pe_valid_o[0]=0 at T0+4, pe_valid_o[1]=0 at T0+5, inputs 0 there, later data shifted one cycle.
REQ-024 w_valid toggling 1,0,1,1,1 -> exactly 4 beats captured; w_valid=1 during STREAM -> w_ready 0, drive values unchanged on next batch.
REQ-025 rst low at T0+4 mid-STREAM -> next cycle all pe_* 0, w_ready 1, no done pulse.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic-array feeder blocks.
package tpu_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        LOAD_W,
        DRIVE_W,
        SWITCH,
        STREAM,
        DRAIN
    } feeder_state_t;

    // Bits needed to count 0..range_n-1, never less than one.
    function automatic int cnt_width(input int range_n);
        return (range_n < 2) ? 1 : $clog2(range_n);
    endfunction

endpackage

// File: rtl/skew_delay.sv
// One row of the west-edge skew line: DEPTH+1 register stages carrying data, valid and switch,
// so row r lands r cycles after row 0.
module skew_delay #(
    parameter int DEPTH      = 0,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  valid,
    input  logic                  sw,
    output logic [DATA_WIDTH-1:0] data_dly,
    output logic                  valid_dly,
    output logic                  sw_dly
);

    logic [DATA_WIDTH-1:0] data_q [DEPTH+1];
    logic [DEPTH:0]        valid_q;
    logic [DEPTH:0]        sw_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i <= DEPTH; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
            sw_q    <= '0;
        end else begin
            data_q[0]  <= data;
            valid_q[0] <= valid;
            sw_q[0]    <= sw;
            for (int i = 1; i <= DEPTH; i++) begin
                data_q[i]  <= data_q[i-1];
                valid_q[i] <= valid_q[i-1];
                sw_q[i]    <= sw_q[i-1];
            end
        end
    end

    assign data_dly  = data_q[DEPTH];
    assign valid_dly = valid_q[DEPTH];
    assign sw_dly    = sw_q[DEPTH];

endmodule

// File: rtl/tile_feeder.sv
// Tile feeder: captures a ROWS x COLS weight tile, drives it north bottom row first,
// then streams input vectors west through a per-row skew line.
module tile_feeder
    import tpu_pkg::*;
#(
    parameter int ROWS       = 2,
    parameter int COLS       = 2,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       w_valid,
    output logic                       w_ready,
    input  logic [DATA_WIDTH-1:0]      w_data,
    input  logic                       x_valid,
    output logic                       x_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] x_data,
    input  logic                       x_last,
    output logic [COLS*DATA_WIDTH-1:0] pe_weight_o,
    output logic [COLS-1:0]            pe_accept_w_o,
    output logic [ROWS*DATA_WIDTH-1:0] pe_input_o,
    output logic [ROWS-1:0]            pe_valid_o,
    output logic [ROWS-1:0]            pe_switch_o,
    output logic                       busy,
    output logic                       done
);

    localparam int NW    = ROWS * COLS;
    localparam int IDX_W = cnt_width(NW);
    localparam int ROW_W = cnt_width(ROWS);

    feeder_state_t state, state_nxt;

    logic [IDX_W-1:0]          idx;
    logic [ROW_W-1:0]          k;
    logic [ROW_W-1:0]          drain_cnt;
    logic [DATA_WIDTH-1:0]     tile [NW];
    logic                      w_fire, x_fire;
    logic                      last_beat, k_last, drain_last;
    logic                      inj_valid, inj_switch;
    logic [ROWS*DATA_WIDTH-1:0] inj_data;

    assign w_fire     = w_valid && w_ready;
    assign x_fire     = x_valid && x_ready;
    assign last_beat  = (idx == IDX_W'(NW - 1));
    assign k_last     = (k == ROW_W'(ROWS - 1));
    assign drain_last = (drain_cnt == ROW_W'(ROWS - 1));

    // Bubbles enter the skew line with zero data so an idle row never shows stale input.
    assign inj_valid  = x_fire;
    assign inj_data   = x_fire ? x_data : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= LOAD_W;
            idx       <= '0;
            k         <= '0;
            drain_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (w_fire) begin
                idx <= last_beat ? '0 : idx + 1'b1;
            end
            if (state == DRIVE_W) begin
                k <= k_last ? '0 : k + 1'b1;
            end
            if (state == DRAIN) begin
                drain_cnt <= drain_last ? '0 : drain_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        w_ready    = 1'b0;
        x_ready    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        inj_switch = 1'b0;
        case (state)
            LOAD_W: begin
                w_ready = 1'b1;
                busy    = 1'b0;
                if (w_valid && last_beat) state_nxt = DRIVE_W;
            end
            DRIVE_W: begin
                if (k_last) state_nxt = SWITCH;
            end
            SWITCH: begin
                inj_switch = 1'b1;
                state_nxt  = STREAM;
            end
            STREAM: begin
                x_ready = 1'b1;
                if (x_valid && x_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_last) begin
                    done      = 1'b1;
                    state_nxt = LOAD_W;
                end
            end
            default: state_nxt = LOAD_W;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_fire) begin
            tile[idx] <= w_data;
        end
    end

    // Weight drive is registered, so row ROWS-1-k appears the cycle after DRIVE_W step k.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pe_weight_o   <= '0;
            pe_accept_w_o <= '0;
        end else if (state == DRIVE_W) begin
            for (int c = 0; c < COLS; c++) begin
                pe_weight_o[c*DATA_WIDTH +: DATA_WIDTH] <=
                    tile[IDX_W'((ROWS - 1 - int'(k)) * COLS + c)];
            end
            pe_accept_w_o <= '1;
        end else begin
            pe_weight_o   <= '0;
            pe_accept_w_o <= '0;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        skew_delay #(
            .DEPTH      (r),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_skew (
            .clk       (clk),
            .rst       (rst),
            .data      (inj_data[r*DATA_WIDTH +: DATA_WIDTH]),
            .valid     (inj_valid),
            .sw        (inj_switch),
            .data_dly  (pe_input_o[r*DATA_WIDTH +: DATA_WIDTH]),
            .valid_dly (pe_valid_o[r]),
            .sw_dly    (pe_switch_o[r])
        );
    end

endmodule

// File: tb/tb_tile_feeder.sv
// Scoreboard bench for tile_feeder: the driver derives expected events from batch timing rules,
// a negedge monitor pops and compares them whenever the feeder presents an output.
module tb_tile_feeder;

    localparam int ROWS = 2;
    localparam int COLS = 2;
    localparam int DW   = 16;
    localparam int NW   = ROWS * COLS;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 w_valid = 1'b0;
    logic [DW-1:0]        w_data = '0;
    logic                 x_valid = 1'b0;
    logic [ROWS*DW-1:0]   x_data = '0;
    logic                 x_last = 1'b0;
    logic                 w_ready, x_ready, busy, done;
    logic [COLS*DW-1:0]   pe_weight_o;
    logic [COLS-1:0]      pe_accept_w_o;
    logic [ROWS*DW-1:0]   pe_input_o;
    logic [ROWS-1:0]      pe_valid_o;
    logic [ROWS-1:0]      pe_switch_o;

    typedef struct {
        int          cyc;
        logic [63:0] val;
    } ev_t;

    typedef struct {
        int   cyc;
        logic wr;
        logic xr;
        logic bz;
    } ctrl_t;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
    } litem_t;

    typedef struct {
        logic               v;
        logic [ROWS*DW-1:0] d;
        logic               l;
    } sitem_t;

    ev_t    wq[$];
    ev_t    dq[ROWS][$];
    ev_t    swq[ROWS][$];
    ev_t    doneq[$];
    ctrl_t  ctrlq[$];
    litem_t ld[$];
    sitem_t st[$];

    logic [DW-1:0] mtile [NW];
    int  cyc      = 0;
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  mon_en   = 1'b0;

    tile_feeder #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .DATA_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .w_valid       (w_valid),
        .w_ready       (w_ready),
        .w_data        (w_data),
        .x_valid       (x_valid),
        .x_ready       (x_ready),
        .x_data        (x_data),
        .x_last        (x_last),
        .pe_weight_o   (pe_weight_o),
        .pe_accept_w_o (pe_accept_w_o),
        .pe_input_o    (pe_input_o),
        .pe_valid_o    (pe_valid_o),
        .pe_switch_o   (pe_switch_o),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic junkInputs();
        w_valid = 1'($urandom_range(0, 1));
        w_data  = DW'($urandom);
        x_valid = 1'($urandom_range(0, 1));
        x_data  = (ROWS*DW)'({$urandom, $urandom});
        x_last  = 1'($urandom_range(0, 1));
    endtask

    task automatic pushCtrl(input int c, input logic wr, input logic xr, input logic bz);
        ctrl_t e;
        e.cyc = c; e.wr = wr; e.xr = xr; e.bz = bz;
        ctrlq.push_back(e);
    endtask

    task automatic pushEv(input int kind, input int row, input int c, input logic [63:0] v);
        ev_t e;
        e.cyc = c; e.val = v;
        case (kind)
            0: wq.push_back(e);
            1: dq[row].push_back(e);
            2: swq[row].push_back(e);
            default: doneq.push_back(e);
        endcase
    endtask

    task automatic addLoad(input logic v, input logic [DW-1:0] d);
        litem_t li;
        li.v = v; li.d = d;
        ld.push_back(li);
    endtask

    task automatic addStream(input logic v, input logic [ROWS*DW-1:0] d, input logic l);
        sitem_t si;
        si.v = v; si.d = d; si.l = l;
        st.push_back(si);
    endtask

    // A synchronous reset at cycle n cancels every event scheduled after n.
    task automatic purgeAfter(input int n);
        while (wq.size() > 0 && wq[$].cyc > n) void'(wq.pop_back());
        while (doneq.size() > 0 && doneq[$].cyc > n) void'(doneq.pop_back());
        for (int r = 0; r < ROWS; r++) begin
            while (dq[r].size() > 0 && dq[r][$].cyc > n) void'(dq[r].pop_back());
            while (swq[r].size() > 0 && swq[r][$].cyc > n) void'(swq[r].pop_back());
        end
    endtask

    // kind 0: fixed batch (weights 1..4, vectors [5,6] gap [7,8] [9,10]); otherwise random.
    task automatic applyStimulus(input int kind, input int reset_at);
        litem_t      li;
        sitem_t      si;
        int          beats, t0, a, si_idx, nvec;
        logic [63:0] wv;
        ld.delete();
        st.delete();
        if (kind == 0) begin
            addLoad(1'b1, 16'd1); addLoad(1'b0, 16'h7777); addLoad(1'b1, 16'd2);
            addLoad(1'b1, 16'd3); addLoad(1'b1, 16'd4);
            addStream(1'b1, {16'd6, 16'd5}, 1'b0);
            addStream(1'b0, 32'hDEAD_BEEF, 1'b1);
            addStream(1'b1, {16'd8, 16'd7}, 1'b0);
            addStream(1'b1, {16'd10, 16'd9}, 1'b1);
        end else begin
            for (int b = 0; b < NW; b++) begin
                repeat ($urandom_range(0, 2)) addLoad(1'b0, DW'($urandom));
                addLoad(1'b1, DW'($urandom));
            end
            nvec = (reset_at >= 0) ? 5 : int'($urandom_range(1, 4));
            for (int j = 0; j < nvec; j++) begin
                repeat ($urandom_range(0, 2))
                    addStream(1'b0, (ROWS*DW)'($urandom), 1'($urandom_range(0, 1)));
                addStream(1'b1, (ROWS*DW)'($urandom), j == nvec - 1);
            end
        end

        beats = 0;
        while (ld.size() > 0) begin
            li = ld.pop_front();
            step();
            junkInputs();
            w_valid = li.v;
            w_data  = li.d;
            pushCtrl(cyc, 1'b1, 1'b0, 1'b0);
            if (li.v) begin
                mtile[beats] = li.d;
                beats++;
            end
        end

        // Tile is driven from two cycles after the last beat, bottom row first.
        t0 = cyc + 2;
        for (int kk = 0; kk < ROWS; kk++) begin
            wv = '0;
            for (int c = 0; c < COLS; c++) wv[c*DW +: DW] = mtile[(ROWS - 1 - kk) * COLS + c];
            pushEv(0, 0, t0 + kk, wv);
        end
        for (int r = 0; r < ROWS; r++) pushEv(2, r, t0 + ROWS + r, 64'd1);

        for (int n = cyc + 1; n < t0 + ROWS; n++) begin
            step();
            junkInputs();
            pushCtrl(cyc, 1'b0, 1'b0, 1'b1);
        end

        a = 0;
        si_idx = 0;
        while (st.size() > 0) begin
            si = st.pop_front();
            step();
            if (si_idx == reset_at) begin
                rst = 1'b0; w_valid = 1'b0; x_valid = 1'b0;
                pushCtrl(cyc, 1'b0, 1'b1, 1'b1);
                purgeAfter(cyc);
                step();
                rst = 1'b1;
                pushCtrl(cyc, 1'b1, 1'b0, 1'b0);
                return;
            end
            junkInputs();
            x_valid = si.v;
            x_data  = si.d;
            x_last  = si.l;
            pushCtrl(cyc, 1'b0, 1'b1, 1'b1);
            if (si.v) begin
                for (int r = 0; r < ROWS; r++) pushEv(1, r, cyc + 1 + r, 64'(si.d[r*DW +: DW]));
                if (si.l) begin
                    a = cyc;
                    pushEv(3, 0, a + ROWS, 64'd1);
                end
            end
            si_idx++;
        end

        for (int n = a + 1; n <= a + ROWS; n++) begin
            step();
            junkInputs();
            pushCtrl(cyc, 1'b0, 1'b0, 1'b1);
        end
    endtask

    always @(negedge clk) begin
        ev_t   e;
        ctrl_t c;
        if (mon_en) begin
            while (ctrlq.size() > 0 && ctrlq[0].cyc < cyc) void'(ctrlq.pop_front());
            if (ctrlq.size() > 0 && ctrlq[0].cyc == cyc) begin
                c = ctrlq.pop_front();
                checkOutput("w_ready", 64'(w_ready), 64'(c.wr));
                checkOutput("x_ready", 64'(x_ready), 64'(c.xr));
                checkOutput("busy", 64'(busy), 64'(c.bz));
            end

            while (wq.size() > 0 && wq[0].cyc < cyc) begin
                checkOutput("weight_cycle", 64'(cyc), 64'(wq[0].cyc));
                void'(wq.pop_front());
            end
            if (pe_accept_w_o != '0) begin
                if (wq.size() > 0 && wq[0].cyc == cyc) begin
                    e = wq.pop_front();
                    checkOutput("pe_weight_o", 64'(pe_weight_o), e.val);
                    checkOutput("pe_accept_w_o", 64'(pe_accept_w_o), 64'({COLS{1'b1}}));
                end else begin
                    checkOutput("accept_unexpected", 64'(pe_accept_w_o), 64'd0);
                end
            end else begin
                checkOutput("pe_weight_idle", 64'(pe_weight_o), 64'd0);
            end

            for (int r = 0; r < ROWS; r++) begin
                while (dq[r].size() > 0 && dq[r][0].cyc < cyc) begin
                    checkOutput($sformatf("row%0d_data_cycle", r), 64'(cyc), 64'(dq[r][0].cyc));
                    void'(dq[r].pop_front());
                end
                if (pe_valid_o[r]) begin
                    if (dq[r].size() > 0 && dq[r][0].cyc == cyc) begin
                        e = dq[r].pop_front();
                        checkOutput($sformatf("row%0d_input", r), 64'(pe_input_o[r*DW +: DW]), e.val);
                    end else begin
                        checkOutput($sformatf("row%0d_valid_unexpected", r), 64'd1, 64'd0);
                    end
                end else begin
                    checkOutput($sformatf("row%0d_input_idle", r), 64'(pe_input_o[r*DW +: DW]), 64'd0);
                end

                while (swq[r].size() > 0 && swq[r][0].cyc < cyc) begin
                    checkOutput($sformatf("row%0d_switch_cycle", r), 64'(cyc), 64'(swq[r][0].cyc));
                    void'(swq[r].pop_front());
                end
                if (pe_switch_o[r]) begin
                    if (swq[r].size() > 0 && swq[r][0].cyc == cyc) begin
                        e = swq[r].pop_front();
                        checkOutput($sformatf("row%0d_switch", r), 64'(pe_switch_o[r]), e.val);
                    end else begin
                        checkOutput($sformatf("row%0d_switch_unexpected", r), 64'd1, 64'd0);
                    end
                end
            end

            while (doneq.size() > 0 && doneq[0].cyc < cyc) begin
                checkOutput("done_cycle", 64'(cyc), 64'(doneq[0].cyc));
                void'(doneq.pop_front());
            end
            if (done) begin
                if (doneq.size() > 0 && doneq[0].cyc == cyc) begin
                    e = doneq.pop_front();
                    checkOutput("done", 64'(done), e.val);
                end else begin
                    checkOutput("done_unexpected", 64'd1, 64'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] tile_feeder scoreboard bench starting");
        rst = 1'b0;
        step();
        mon_en = 1'b1;
        pushCtrl(cyc, 1'b1, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        pushCtrl(cyc, 1'b1, 1'b0, 1'b0);

        applyStimulus(0, -1);
        applyStimulus(1, -1);
        applyStimulus(1, -1);
        applyStimulus(1, -1);
        applyStimulus(1, 2);
        applyStimulus(1, -1);
        applyStimulus(1, -1);

        repeat (4) begin
            step();
            w_valid = 1'b0;
            x_valid = 1'b0;
            pushCtrl(cyc, 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        #1;
        mon_en = 1'b0;

        checkOutput("weight_events_left", 64'(wq.size()), 64'd0);
        checkOutput("done_events_left", 64'(doneq.size()), 64'd0);
        for (int r = 0; r < ROWS; r++) begin
            checkOutput($sformatf("row%0d_events_left", r), 64'(dq[r].size()), 64'd0);
            checkOutput($sformatf("row%0d_switch_left", r), 64'(swq[r].size()), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
